lsz_rebuild: RTL and testbench

- Receiver side of the least-significant-zero index stream used by the Sobol-style unary generators.
- The generator side emits, per counter step, the LSZ index k of its current count. This block consumes that index stream with a valid/ready handshake and rebuilds the count value: next = cur XOR ((2 << k) - 1).
- It checks every index against the rebuilt count and flags protocol errors.
- It sits at the consumer end of the index bus and feeds the rebuilt count to downstream comparators and debug logic.

---
 rtl/lsz_rebuild_pkg.sv | 54 +++++
 rtl/lsz_rebuild_if.sv | 34 +++
 rtl/lsz_rebuild_check.sv | 32 +++
 rtl/lsz_rebuild.sv | 103 ++++++++++
 tb/tb_lsz_rebuild.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsz_rebuild_pkg.sv
// ============================================================================
//  Module      : lsz_rebuild_pkg
//  Description : Shared LSZ helpers for the index-stream generator and receiver
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package lsz_rebuild_pkg;

    // Widest count the helpers can describe; counts are zero-extended to this.
    localparam int MAX_W = 32;

    localparam logic [MAX_W-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {
        BEAT_NONE    = 2'd0,
        BEAT_LEGAL   = 2'd1,
        BEAT_ILLEGAL = 2'd2
    } beat_e;

    // (2 << k) - 1, truncated to width bits.
    function automatic logic [MAX_W-1:0] lsz_mask(input int unsigned k,
                                                  input int unsigned width);
        logic [MAX_W:0] m;
        logic [MAX_W:0] w;
        m = ((MAX_W+1)'(1) << (k + 1)) - (MAX_W+1)'(1);
        w = ((MAX_W+1)'(1) << width) - (MAX_W+1)'(1);
        return MAX_W'(m & w);
    endfunction

    // k is legal when every bit below k is set and bit k is clear,
    // except that the top index may also wrap an all-ones count.
    function automatic logic lsz_legal(input logic [MAX_W-1:0] cnt,
                                       input int unsigned      k,
                                       input int unsigned      width);
        logic [MAX_W-1:0] low;
        logic [MAX_W-1:0] full;
        logic             low_ok;
        logic             bit_k;
        logic             is_full;
        if (k >= width) begin
            return 1'b0;
        end
        low     = lsz_mask(k, width) >> 1;
        full    = lsz_mask(width - 1, width);
        low_ok  = (cnt & low) == low;
        bit_k   = ((cnt >> k) & MAX_W'(1)) != '0;
        is_full = (cnt & full) == full;
        return low_ok && (!bit_k || ((k == width - 1) && is_full));
    endfunction

endpackage

`default_nettype wire

// File: rtl/lsz_rebuild_if.sv
// ============================================================================
//  Module      : lsz_rebuild_if
//  Description : Index-stream input and rebuilt-count output bundle
//  Revision    : 1.0
// ============================================================================
`default_nettype none

interface lsz_rebuild_if #(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH)
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LOGBITWIDTH-1:0] idx;
    logic                   out_valid;
    logic                   out_ready;
    logic [BITWIDTH-1:0]    cnt;
    logic                   wrap;
    logic                   err;
    logic [LOGBITWIDTH-1:0] err_idx;
    logic [LOGBITWIDTH:0]   err_cnt;

    modport master (
        output in_valid, idx, out_ready,
        input  in_ready, out_valid, cnt, wrap, err, err_idx, err_cnt
    );

    modport slave (
        input  in_valid, idx, out_ready,
        output in_ready, out_valid, cnt, wrap, err, err_idx, err_cnt
    );
endinterface

`default_nettype wire

// File: rtl/lsz_rebuild_check.sv
// ============================================================================
//  Module      : lsz_rebuild_check
//  Description : Combinational legality and next-count for one LSZ index
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module lsz_rebuild_check
    import lsz_rebuild_pkg::*;
#(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH)
) (
    input  wire logic [BITWIDTH-1:0]    cnt,
    input  wire logic [LOGBITWIDTH-1:0] idx,
    output logic                        legal,
    output logic [BITWIDTH-1:0]         next_cnt,
    output logic                        wrap
);

    logic [31:0] w_k;

    always_comb begin
        w_k      = 32'(idx);
        legal    = lsz_legal(MAX_W'(cnt), w_k, BITWIDTH);
        next_cnt = cnt ^ BITWIDTH'(lsz_mask(w_k, BITWIDTH));
        wrap     = (cnt == ALL_ONES[BITWIDTH-1:0]);
    end

endmodule

`default_nettype wire

// File: rtl/lsz_rebuild.sv
// ============================================================================
//  Module      : lsz_rebuild
//  Description : Rebuilds a unary-generator count from its LSZ index stream
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module lsz_rebuild
    import lsz_rebuild_pkg::*;
#(
    parameter int BITWIDTH    = 4,
    parameter int LOGBITWIDTH = $clog2(BITWIDTH)
) (
    input  wire logic    clk,
    input  wire logic    rst,
    input  wire logic    clr,
    lsz_rebuild_if.slave bus
);

    localparam logic [LOGBITWIDTH:0] ERR_SAT = '1;

    logic                   w_legal;
    logic                   w_wrap;
    logic [BITWIDTH-1:0]    w_next;
    beat_e                  w_beat;

    logic [BITWIDTH-1:0]    r_cnt;
    logic                   r_valid;
    logic                   r_wrap;
    logic                   r_err;
    logic [LOGBITWIDTH-1:0] r_err_idx;
    logic [LOGBITWIDTH:0]   r_err_cnt;

    lsz_rebuild_check #(
        .BITWIDTH    (BITWIDTH),
        .LOGBITWIDTH (LOGBITWIDTH)
    ) u_check (
        .cnt      (r_cnt),
        .idx      (bus.idx),
        .legal    (w_legal),
        .next_cnt (w_next),
        .wrap     (w_wrap)
    );

    // Single output register, no skid: only accept when the slot is free or draining.
    assign bus.in_ready = ~rst & ~clr & (~r_valid | bus.out_ready);

    always_comb begin
        w_beat = BEAT_NONE;
        if (bus.in_valid && bus.in_ready) begin
            w_beat = w_legal ? BEAT_LEGAL : BEAT_ILLEGAL;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt     <= '0;
            r_valid   <= 1'b0;
            r_wrap    <= 1'b0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
            r_err_cnt <= '0;
        end else begin
            case (w_beat)
                BEAT_LEGAL: begin
                    r_cnt   <= w_next;
                    r_valid <= 1'b1;
                    r_wrap  <= w_wrap;
                end
                BEAT_ILLEGAL: begin
                    // Rejected beats leave the count and output slot alone.
                    if (r_valid && bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_wrap  <= 1'b0;
                    end
                    r_err <= 1'b1;
                    if (!r_err) begin
                        r_err_idx <= bus.idx;
                    end
                    if (r_err_cnt != ERR_SAT) begin
                        r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end
                default: begin
                    if (r_valid && bus.out_ready) begin
                        r_valid <= 1'b0;
                        r_wrap  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.cnt       = r_cnt;
    assign bus.wrap      = r_wrap;
    assign bus.err       = r_err;
    assign bus.err_idx   = r_err_idx;
    assign bus.err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lsz_rebuild.sv
// ============================================================================
//  Module      : tb_lsz_rebuild
//  Description : Scoreboard bench for lsz_rebuild (BITWIDTH 4 and 5)
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_lsz_rebuild;

    logic clk = 1'b0;
    logic rst;
    logic clr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [4:0] exp_q[$];

    lsz_rebuild_if #(.BITWIDTH(4)) bus ();
    lsz_rebuild_if #(.BITWIDTH(5)) bus5 ();

    lsz_rebuild #(.BITWIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .bus (bus)
    );

    lsz_rebuild #(.BITWIDTH(5)) dut5 (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .bus (bus5)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Output monitor: every completed output handshake must match the queue head.
    always @(negedge clk) begin
        logic [4:0] e;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_beat: got cnt %0d with no expected beat", bus.cnt);
            end else begin
                e = exp_q.pop_front();
                check("out_cnt", 32'(bus.cnt), 32'(e[3:0]));
                check("out_wrap", 32'(bus.wrap), 32'(e[4]));
            end
        end
    end

    // Starts and ends 1 time unit after a rising edge.
    task automatic send(input logic [1:0] k, input bit push, input logic [3:0] ecnt, input bit ewrap);
        int waited;
        bus.in_valid = 1'b1;
        bus.idx      = k;
        if (push) exp_q.push_back({ewrap, ecnt});
        waited = 0;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            waited++;
            if (waited > 20) begin
                n_checks++;
                $display("FAIL accept_timeout: got no in_ready after %0d cycles, required 1", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0] seq [15];
        seq = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
                2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};

        rst = 1'b1;
        clr = 1'b0;
        bus.in_valid  = 1'b0;
        bus.idx       = '0;
        bus.out_ready = 1'b1;
        bus5.in_valid  = 1'b0;
        bus5.idx       = '0;
        bus5.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_cnt", 32'(bus.cnt), 0);
        check("rst_wrap", 32'(bus.wrap), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_err_idx", 32'(bus.err_idx), 0);
        check("rst_err_cnt", 32'(bus.err_cnt), 0);
        check("rst_in_ready", 32'(bus.in_ready), 1);

        // Out-of-range index on the 5-bit instance.
        @(posedge clk);
        #1;
        bus5.in_valid = 1'b1;
        bus5.idx      = 3'd6;
        @(negedge clk);
        check("w5_in_ready", 32'(bus5.in_ready), 1);
        @(posedge clk);
        #1 bus5.in_valid = 1'b0;
        check("w5_err", 32'(bus5.err), 1);
        check("w5_err_idx", 32'(bus5.err_idx), 6);
        check("w5_err_cnt", 32'(bus5.err_cnt), 1);
        check("w5_out_valid", 32'(bus5.out_valid), 0);
        check("w5_cnt", 32'(bus5.cnt), 0);

        // Full count 1..15, then wrap.
        for (int i = 0; i < 15; i++) begin
            send(seq[i], 1'b1, 4'(i + 1), 1'b0);
        end
        send(2'd3, 1'b1, 4'd0, 1'b1);
        send(2'd0, 1'b1, 4'd1, 1'b0);
        check("run_err", 32'(bus.err), 0);

        // Illegal beats at cnt=1.
        send(2'd0, 1'b0, 4'd0, 1'b0);
        check("ill1_err", 32'(bus.err), 1);
        check("ill1_err_idx", 32'(bus.err_idx), 0);
        check("ill1_err_cnt", 32'(bus.err_cnt), 1);
        check("ill1_cnt", 32'(bus.cnt), 1);
        send(2'd2, 1'b0, 4'd0, 1'b0);
        check("ill2_err_idx", 32'(bus.err_idx), 0);
        check("ill2_err_cnt", 32'(bus.err_cnt), 2);
        check("ill2_cnt", 32'(bus.cnt), 1);
        send(2'd1, 1'b1, 4'd2, 1'b0);
        check("post_ill_err", 32'(bus.err), 1);

        // Backpressure with oCnt=5 held.
        send(2'd0, 1'b1, 4'd3, 1'b0);
        send(2'd2, 1'b1, 4'd4, 1'b0);
        send(2'd0, 1'b1, 4'd5, 1'b0);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.idx       = 2'd1;
        repeat (3) begin
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 0);
            check("bp_cnt", 32'(bus.cnt), 5);
            check("bp_out_valid", 32'(bus.out_valid), 1);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        send(2'd1, 1'b1, 4'd6, 1'b0);

        // Clear at cnt=9 with the error flag set.
        send(2'd0, 1'b1, 4'd7, 1'b0);
        send(2'd3, 1'b1, 4'd8, 1'b0);
        send(2'd0, 1'b1, 4'd9, 1'b0);
        clr = 1'b1;
        bus.in_valid = 1'b1;
        bus.idx      = 2'd0;
        @(negedge clk);
        check("clr_in_ready", 32'(bus.in_ready), 0);
        check("clr_pre_err", 32'(bus.err), 1);
        @(posedge clk);
        #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_out_valid", 32'(bus.out_valid), 0);
        check("clr_cnt", 32'(bus.cnt), 0);
        check("clr_err", 32'(bus.err), 0);
        check("clr_err_cnt", 32'(bus.err_cnt), 0);
        send(2'd0, 1'b1, 4'd1, 1'b0);

        // Reset while a beat is stalled.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send(2'd1, 1'b0, 4'd0, 1'b0);
        check("stall_cnt", 32'(bus.cnt), 2);
        check("stall_out_valid", 32'(bus.out_valid), 1);
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.idx      = 2'd0;
        @(negedge clk);
        check("rst_mid_in_ready", 32'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.in_valid  = 1'b0;
        check("rst_mid_out_valid", 32'(bus.out_valid), 0);
        check("rst_mid_cnt", 32'(bus.cnt), 0);
        check("rst_mid_wrap", 32'(bus.wrap), 0);
        check("rst_mid_err", 32'(bus.err), 0);
        check("rst_mid_err_cnt", 32'(bus.err_cnt), 0);
        bus.out_ready = 1'b1;

        // Error counter saturation: idx 1 is illegal at cnt=0.
        repeat (9) send(2'd1, 1'b0, 4'd0, 1'b0);
        check("sat_err_cnt", 32'(bus.err_cnt), 7);
        check("sat_err_idx", 32'(bus.err_idx), 1);
        check("sat_cnt", 32'(bus.cnt), 0);
        check("sat_out_valid", 32'(bus.out_valid), 0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
